// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display arbiter:
// owner state encoding, blank anode pattern, anode decode and BCD digit select.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] AN_BLANK = 4'b1111;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] an_mask(input logic [1:0] idx);
    logic [3:0] m;
    m      = AN_BLANK;
    m[idx] = 1'b0;
    return m;
  endfunction

  function automatic logic [3:0] bcd_sel(input logic [1:0] idx, input logic [15:0] data);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = data[3:0];
      2'd1:    nib = data[7:4];
      2'd2:    nib = data[11:8];
      default: nib = data[15:12];
    endcase
    return nib;
  endfunction

  function automatic logic [1:0] gnt_of(input state_t st);
    logic [1:0] g;
    case (st)
      ST_OWN0: g = 2'b01;
      ST_OWN1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_core.sv
// Digit scan engine: prescaler plus 2-bit digit index with a per-frame latched
// digit count. idx_o is the index that is in effect after the coming edge.
module seg_scan_core
  import seg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en_i,
  input  logic       restart_i,
  input  logic [1:0] ndig_i,
  output logic [1:0] idx_o,
  output logic       adv_o
);

  localparam int unsigned   PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    ndig_q, ndig_d;
  logic          term;

  assign term = (pre_q == PRE_MAX);

  // The digit count is re-latched only when the index wraps, so a count change
  // never truncates or stretches the frame that is currently being shown.
  always_comb begin
    pre_d  = pre_q;
    idx_d  = idx_q;
    ndig_d = ndig_q;
    if (restart_i) begin
      pre_d  = '0;
      idx_d  = 2'd0;
      ndig_d = ndig_i;
    end else if (!en_i) begin
      pre_d = '0;
      idx_d = 2'd0;
    end else if (term) begin
      pre_d = '0;
      if (idx_q == ndig_q) begin
        idx_d  = 2'd0;
        ndig_d = ndig_i;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      idx_q  <= 2'd0;
      ndig_q <= 2'd0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      ndig_q <= ndig_d;
    end
  end

  assign idx_o = idx_d;
  assign adv_o = en_i && !restart_i && term;

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-source arbiter for the shared 4-digit 7-segment display: time-sliced
// grant with minimum hold, and registered anode/nibble outputs for the owner.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50,
  parameter int unsigned HOLD_CYC = 1000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [1:0]  ndig0,
  input  logic [1:0]  ndig1,
  output logic [1:0]  gnt,
  output logic [3:0]  an_scan,
  output logic [3:0]  num,
  output logic        busy
);

  localparam int unsigned   HW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q;
  logic [1:0]    gnt_q;
  logic [3:0]    an_scan_q;
  logic [3:0]    num_q;

  logic          restart;
  logic          scan_en;
  logic [1:0]    ndig_sel;
  logic [15:0]   data_sel;
  logic [1:0]    scan_idx;
  logic          scan_adv;

  // A dropped request hands over at once; a held one yields only after the hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req[1])      state_d = ST_OWN1;
        else if (req[0]) state_d = ST_OWN0;
      end
      ST_OWN0: begin
        if (!req[0])                          state_d = req[1] ? ST_OWN1 : ST_IDLE;
        else if (req[1] && hold_q == HOLD_MAX) state_d = ST_OWN1;
      end
      ST_OWN1: begin
        if (!req[1])                          state_d = req[0] ? ST_OWN0 : ST_IDLE;
        else if (req[0] && hold_q == HOLD_MAX) state_d = ST_OWN0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign scan_en  = (state_d != ST_IDLE);
  assign restart  = scan_en && (state_d != state_q);
  assign ndig_sel = (state_d == ST_OWN1) ? ndig1 : ndig0;
  assign data_sel = (state_d == ST_OWN1) ? data1 : data0;

  seg_scan_core #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk_in    (clk_in),
    .rst       (rst),
    .en_i      (scan_en),
    .restart_i (restart),
    .ndig_i    (ndig_sel),
    .idx_o     (scan_idx),
    .adv_o     (scan_adv)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      gnt_q     <= 2'b00;
      an_scan_q <= AN_BLANK;
      num_q     <= 4'h0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_of(state_d);
      if (restart || !scan_en) hold_q <= '0;
      else if (hold_q != HOLD_MAX) hold_q <= hold_q + HW'(1);
      if (!scan_en) an_scan_q <= AN_BLANK;
      else if (restart || scan_adv) an_scan_q <= an_mask(scan_idx);
      num_q <= scan_en ? bcd_sel(scan_idx, data_sel) : 4'h0;
    end
  end

  assign gnt     = gnt_q;
  assign an_scan = an_scan_q;
  assign num     = num_q;
  assign busy    = |gnt_q;

endmodule
